// File: rtl/imm_gen_pkg.sv
// Shared types for the pipelined RV32I immediate generator: format codes,
// major opcodes and the buffered entry layout.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_Z   = 3'd6,
        FMT_ILL = 3'd7
    } fmt_e;

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam int IMM_W_MAX = 64;

    // Entries are sized for the widest legal XLEN; narrower builds drop the top bits.
    typedef struct packed {
        logic [IMM_W_MAX-1:0] imm;
        fmt_e                 fmt;
    } entry_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational instruction-word to {immediate, format} decoder.
// Optional IMM_ZIMM_CSR_EN: CSR*I instructions decode as zero-extended zimm (FMT_Z).
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm,
    output fmt_e            o_fmt
);

    always_comb begin
        o_imm = '0;
        o_fmt = FMT_ILL;
        case (i_instr[6:0])
            OPC_OPIMM, OPC_LOAD, OPC_JALR: begin
                o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
                o_fmt = FMT_I;
            end
            OPC_SYSTEM: begin
`ifdef IMM_ZIMM_CSR_EN
                if (i_instr[14]) begin
                    o_imm = {{(XLEN-5){1'b0}}, i_instr[19:15]};
                    o_fmt = FMT_Z;
                end else begin
                    o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
                    o_fmt = FMT_I;
                end
`else
                o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
                o_fmt = FMT_I;
`endif
            end
            OPC_STORE: begin
                o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
                o_fmt = FMT_S;
            end
            OPC_BRANCH: begin
                o_imm = {{(XLEN-13){i_instr[31]}}, i_instr[31], i_instr[7],
                         i_instr[30:25], i_instr[11:8], 1'b0};
                o_fmt = FMT_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                o_imm = {{(XLEN-32){i_instr[31]}}, i_instr[31:12], 12'b0};
                o_fmt = FMT_U;
            end
            OPC_JAL: begin
                o_imm = {{(XLEN-21){i_instr[31]}}, i_instr[31], i_instr[19:12],
                         i_instr[20], i_instr[30:21], 1'b0};
                o_fmt = FMT_J;
            end
            OPC_OP: begin
                o_imm = '0;
                o_fmt = FMT_R;
            end
            default: begin
                o_imm = '0;
                o_fmt = FMT_ILL;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator: decode, 2-entry valid/ready skid buffer, saturating illegal-opcode counter.
// Build option IMM_ZIMM_CSR_EN (handled in imm_decode) enables the zimm CSR format.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [31:0]      INSTR,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [XLEN-1:0]  IMM,
    output logic [2:0]       FMT,
    output logic [CNT_W-1:0] ILL_CNT
);

    logic [XLEN-1:0]  w_dec_imm;
    fmt_e             w_dec_fmt;
    entry_t           w_entry;
    logic             w_push;
    logic             w_pop;

    entry_t           r_head;
    entry_t           r_tail;
    logic [1:0]       r_count;
    logic [CNT_W-1:0] r_ill_cnt;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .i_instr (INSTR),
        .o_imm   (w_dec_imm),
        .o_fmt   (w_dec_fmt)
    );

    // Widen the decoded immediate to the entry width by sign extension.
    generate
        if (XLEN == IMM_W_MAX) begin : g_full
            assign w_entry.imm = w_dec_imm;
        end else begin : g_narrow
            logic w_unused_hi;
            assign w_entry.imm = {{(IMM_W_MAX-XLEN){w_dec_imm[XLEN-1]}}, w_dec_imm};
            assign w_unused_hi = ^r_head.imm[IMM_W_MAX-1:XLEN];
        end
    endgenerate
    assign w_entry.fmt = w_dec_fmt;

    assign IN_READY  = (r_count < 2'd2) && !RST;
    assign OUT_VALID = (r_count != 2'd0);
    assign w_push    = IN_VALID && IN_READY;
    assign w_pop     = OUT_VALID && OUT_READY;

    assign IMM     = r_head.imm[XLEN-1:0];
    assign FMT     = r_head.fmt;
    assign ILL_CNT = r_ill_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= 2'd0;
            r_ill_cnt <= '0;
        end else begin
            // Head is always the oldest entry; tail only holds the second one.
            if (w_pop) begin
                if (r_count == 2'd2) begin
                    r_head <= r_tail;
                end else if (w_push) begin
                    r_head <= w_entry;
                end
            end else if (w_push) begin
                if (r_count == 2'd0) begin
                    r_head <= w_entry;
                end else begin
                    r_tail <= w_entry;
                end
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase

            if (w_push && (w_dec_fmt == FMT_ILL) && (r_ill_cnt != {CNT_W{1'b1}})) begin
                r_ill_cnt <= r_ill_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe: a default instance (XLEN=32, CNT_W=8)
// and a second instance (XLEN=64, CNT_W=2) driven by the same stimulus.
module tb_imm_gen_pipe;

    logic        CLK;
    logic        RST;
    logic        IN_VALID;
    logic [31:0] INSTR;
    logic        OUT_READY;

    logic        IN_READY;
    logic        OUT_VALID;
    logic [31:0] IMM;
    logic [2:0]  FMT;
    logic [7:0]  ILL_CNT;

    logic        w64_in_ready;
    logic        w64_out_valid;
    logic [63:0] w64_imm;
    logic [2:0]  w64_fmt;
    logic [1:0]  w64_ill_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    imm_gen_pipe #(.XLEN(32), .CNT_W(8)) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .INSTR     (INSTR),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .IMM       (IMM),
        .FMT       (FMT),
        .ILL_CNT   (ILL_CNT)
    );

    imm_gen_pipe #(.XLEN(64), .CNT_W(2)) u_dut64 (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (w64_in_ready),
        .INSTR     (INSTR),
        .OUT_VALID (w64_out_valid),
        .OUT_READY (OUT_READY),
        .IMM       (w64_imm),
        .FMT       (w64_fmt),
        .ILL_CNT   (w64_ill_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %-16s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; IN_VALID = 1'b0; INSTR = 32'h0; OUT_READY = 1'b0;
        step();
        step();
        chk("rst_in_ready",   {63'd0, IN_READY},  64'd0);
        chk("rst_out_valid",  {63'd0, OUT_VALID}, 64'd0);
        chk("rst_imm",        {32'd0, IMM},       64'd0);
        chk("rst_fmt",        {61'd0, FMT},       64'd0);
        chk("rst_ill_cnt",    {56'd0, ILL_CNT},   64'd0);
        RST = 1'b0;
        #1;
        chk("post_rst_ready", {63'd0, IN_READY},  64'd1);

        // addi -1
        IN_VALID = 1'b1; INSTR = 32'hFFF00093; OUT_READY = 1'b1;
        step();
        chk("addi_valid",     {63'd0, OUT_VALID}, 64'd1);
        chk("addi_imm",       {32'd0, IMM},       64'hFFFF_FFFF);
        chk("addi_fmt",       {61'd0, FMT},       64'd1);
        chk("addi_imm64",     w64_imm,            64'hFFFF_FFFF_FFFF_FFFF);

        // Back-to-back S, B, U at one per cycle
        INSTR = 32'hFE112E23;
        step();
        chk("s_imm",          {32'd0, IMM},       64'hFFFF_FFFC);
        chk("s_fmt",          {61'd0, FMT},       64'd2);
        chk("s_imm64",        w64_imm,            64'hFFFF_FFFF_FFFF_FFFC);
        INSTR = 32'hFE000CE3;
        step();
        chk("b_imm",          {32'd0, IMM},       64'hFFFF_FFF8);
        chk("b_fmt",          {61'd0, FMT},       64'd3);
        INSTR = 32'h123450B7;
        step();
        chk("u_imm",          {32'd0, IMM},       64'h1234_5000);
        chk("u_fmt",          {61'd0, FMT},       64'd4);
        chk("u_imm64",        w64_imm,            64'h0000_0000_1234_5000);
        IN_VALID = 1'b0;
        step();
        chk("drain_valid",    {63'd0, OUT_VALID}, 64'd0);
        chk("legal_ill_cnt",  {56'd0, ILL_CNT},   64'd0);

        // Backpressure: fill two entries, third held off
        OUT_READY = 1'b0; IN_VALID = 1'b1; INSTR = 32'h00500093;
        step();
        chk("bp1_ready",      {63'd0, IN_READY},  64'd1);
        chk("bp1_imm",        {32'd0, IMM},       64'd5);
        INSTR = 32'h02A00113;
        step();
        chk("bp2_ready",      {63'd0, IN_READY},  64'd0);
        chk("bp2_imm",        {32'd0, IMM},       64'd5);
        INSTR = 32'hABCDE0B7;
        step();
        chk("bp_hold_imm",    {32'd0, IMM},       64'd5);
        chk("bp_hold_fmt",    {61'd0, FMT},       64'd1);
        chk("bp_hold_valid",  {63'd0, OUT_VALID}, 64'd1);
        step();
        chk("bp_hold_imm2",   {32'd0, IMM},       64'd5);
        chk("bp_hold_rdy64",  {63'd0, w64_in_ready}, 64'd0);
        OUT_READY = 1'b1;
        step();
        chk("bp_second_imm",  {32'd0, IMM},       64'd42);
        chk("bp_second_rdy",  {63'd0, IN_READY},  64'd1);
        step();
        chk("bp_third_imm",   {32'd0, IMM},       64'hABCD_E000);
        chk("bp_third_fmt",   {61'd0, FMT},       64'd4);
        chk("bp_third_imm64", w64_imm,            64'hFFFF_FFFF_ABCD_E000);
        IN_VALID = 1'b0;
        step();
        chk("bp_empty",       {63'd0, OUT_VALID}, 64'd0);

        // Illegal opcodes and counter saturation
        IN_VALID = 1'b1; INSTR = 32'h0000_0000;
        step();
        chk("ill_fmt",        {61'd0, FMT},       64'd7);
        chk("ill_imm",        {32'd0, IMM},       64'd0);
        step();
        step();
        chk("ill_cnt3",       {56'd0, ILL_CNT},   64'd3);
        chk("ill_cnt3_w2",    {62'd0, w64_ill_cnt}, 64'd3);
        step();
        step();
        chk("ill_cnt5",       {56'd0, ILL_CNT},   64'd5);
        chk("ill_sat_w2",     {62'd0, w64_ill_cnt}, 64'd3);
        IN_VALID = 1'b0;
        step();

        // csrrwi
        IN_VALID = 1'b1; INSTR = 32'h300FD073;
        step();
`ifdef IMM_ZIMM_CSR_EN
        chk("csr_imm",        {32'd0, IMM},       64'h1F);
        chk("csr_fmt",        {61'd0, FMT},       64'd6);
`else
        chk("csr_imm",        {32'd0, IMM},       64'h300);
        chk("csr_fmt",        {61'd0, FMT},       64'd1);
`endif
        IN_VALID = 1'b0;
        step();

        // Reset with a full buffer
        OUT_READY = 1'b0; IN_VALID = 1'b1; INSTR = 32'h0000_0000;
        step();
        step();
        chk("full_ready",     {63'd0, IN_READY},  64'd0);
        chk("full_ill_cnt",   {56'd0, ILL_CNT},   64'd7);
        RST = 1'b1; IN_VALID = 1'b0;
        step();
        chk("mid_rst_ready",  {63'd0, IN_READY},  64'd0);
        chk("mid_rst_valid",  {63'd0, OUT_VALID}, 64'd0);
        chk("mid_rst_ill",    {56'd0, ILL_CNT},   64'd0);
        chk("mid_rst_fmt",    {61'd0, FMT},       64'd0);
        RST = 1'b0;
        #1;
        chk("mid_rst_after",  {63'd0, IN_READY},  64'd1);
        IN_VALID = 1'b1; OUT_READY = 1'b1; INSTR = 32'h00500093;
        step();
        chk("restart_imm",    {32'd0, IMM},       64'd5);
        chk("restart_valid",  {63'd0, OUT_VALID}, 64'd1);
        IN_VALID = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined immediate generator for the RV32I datapath, replacing the fixed 12-bit zero-extender between fetch/decode and the ALU operand mux. Each accepted 32-bit instruction word is decoded by opcode into its RISC-V immediate format (I/S/B/U/J, R = none). The immediate is sign-extended to XLEN and delivered through a 2-entry valid/ready skid buffer. A saturating counter tracks accepted words with unrecognised opcodes.

## Interface
- XLEN, 32: output immediate width; legal values 32 or 64.
- CNT_W, 8: width of the illegal-opcode counter.
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous, active-high reset.
- IN_VALID  in  1  instruction word valid.
- IN_READY  out  1  block can accept a word this cycle.
- INSTR  in  32  instruction word.
- OUT_VALID  out  1  immediate entry valid at head.
- OUT_READY  in  1  consumer accepts head entry.
- IMM  out  XLEN  extended immediate of head entry.
- FMT  out  3  format code of head entry: R=0, I=1, S=2, B=3, U=4, J=5, Z=6, ILL=7.
- ILL_CNT  out  CNT_W  count of accepted words classified ILL.

## Operation
- Push when IN_VALID && IN_READY. Pop when OUT_VALID && OUT_READY.
- Opcode INSTR[6:0] decode:
  - 0010011, 0000011, 1100111, 1110011 → I: imm = sext(INSTR[31:20]).
  - 0100011 → S: sext({INSTR[31:25],INSTR[11:7]}).
  - 1100011 → B: sext({INSTR[31],INSTR[7],INSTR[30:25],INSTR[11:8],1'b0}).
  - 0110111, 0010111 → U: sext({INSTR[31:12],12'b0}).
  - 1101111 → J: sext({INSTR[31],INSTR[19:12],INSTR[20],INSTR[30:21],1'b0}).
  - 0110011 → R: imm = 0.
  - Anything else → ILL: imm = 0.
- All sign extension replicates the top source bit up to XLEN-1. XLEN=64 changes only the extension width.
- Buffer: 2 entries, FIFO order. Head entry drives IMM/FMT.
  - IN_READY = (count < 2) && !RST.
  - OUT_VALID = (count > 0).
- Push and pop in the same cycle at count 1: count stays 1 and the new entry becomes head on the next edge.
- Push is impossible at count 2. Pop at count 0 is ignored.
- ILL_CNT increments on each push classified ILL and saturates at all-ones. It does not increment on pop or when held off by IN_READY=0.
- While OUT_VALID=1 and OUT_READY=0, IMM/FMT hold stable.

## Timing
- Decode is combinational on INSTR and is registered into the buffer at push.
- Latency: a word pushed at edge N is at the head with OUT_VALID=1 after edge N (visible in cycle N+1) if the buffer was empty or the head popped at N.
- Throughput: 1 word/cycle with OUT_READY held high.
- Reset values: OUT_VALID=0, IMM=0, FMT=0, ILL_CNT=0, count=0.
- IN_READY=0 while RST is high and 1 in the first cycle after RST deasserts.
- RST mid-operation discards all buffered entries at the reset edge. No partial state survives.

## Configuration
- IMM_ZIMM_CSR_EN defined: opcode 1110011 with INSTR[14]=1 (CSRRWI/CSRRSI/CSRRCI) gives FMT=Z and imm = zero-extended INSTR[19:15]. Opcode 1110011 with INSTR[14]=0 stays I.
- IMM_ZIMM_CSR_EN undefined: all of opcode 1110011 is I-type, and FMT value 6 never appears.

## Structure
- Package imm_gen_pkg holds:
  - the fmt_e enum (3 bits, codes above);
  - opcode localparams (OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP);
  - an entry struct {imm, fmt}.
- Sub-module imm_decode: purely combinational INSTR → {imm, fmt}, parametrised by XLEN. The top level holds the buffer, handshake and counter.

## Test plan
- Reset then push 0xFFF00093 (addi -1) with OUT_READY=1 → next cycle OUT_VALID=1, IMM=0xFFFFFFFF, FMT=1.
- Push 0xFE112E23, 0xFE000CE3, 0x123450B7 back-to-back → IMM 0xFFFFFFFC/S, 0xFFFFFFF8/B, 0x12345000/U in order, one per cycle. With XLEN=64 the first is 0xFFFFFFFFFFFFFFFC.
- OUT_READY=0, push 3 words → IN_READY drops after 2 pushes, third held, IMM stable; raise OUT_READY → all 3 emerge in order, no loss or duplication.
- Push 0x00000000 three times → FMT=7, IMM=0, ILL_CNT=3. With CNT_W=2 and 5 illegal pushes → ILL_CNT saturates at 3.
- Push 0x300FD073 (csrrwi) → with IMM_ZIMM_CSR_EN: IMM=0x1F, FMT=6; without it: IMM=0x300, FMT=1.
- Fill to 2 entries, assert RST one cycle → OUT_VALID=0, ILL_CNT=0, IN_READY=0 during reset and 1 the cycle after.
